// File: rtl/sprite_frame_renderer_if.sv
// Command, sprite-memory and VGA scan signals of sprite_frame_renderer.
interface sprite_frame_renderer_if #(
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int PIX_W = 8,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int N_SPR = 16
);
  localparam int XW  = $clog2(FB_W);
  localparam int YW  = $clog2(FB_H);
  localparam int IDW = $clog2(N_SPR);
  localparam int SAW = $clog2(N_SPR * SPR_W * SPR_H);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [IDW+XW+YW-1:0]   cmd_data;
  logic                   do_render;
  logic                   busy;
  logic                   done_rendering;
  logic [SAW-1:0]         spr_addr;
  logic                   spr_rd;
  logic [PIX_W-1:0]       spr_din;
  logic [9:0]             scan_x;
  logic [9:0]             scan_y;
  logic                   scan_active;
  logic                   frame_start;
  logic [PIX_W-1:0]       pix_data;

  modport master (
    output cmd_valid, cmd_data, do_render, spr_din, scan_x, scan_y, scan_active, frame_start,
    input  cmd_ready, busy, done_rendering, spr_addr, spr_rd, pix_data
  );

  modport slave (
    input  cmd_valid, cmd_data, do_render, spr_din, scan_x, scan_y, scan_active, frame_start,
    output cmd_ready, busy, done_rendering, spr_addr, spr_rd, pix_data
  );
endinterface

// File: rtl/sprite_frame_renderer.sv
// Queued sprite blitter into a double-buffered framebuffer with upscaled scan-out.
// IDLE take cmds | CLEAR fill back with BG | FETCH pop cmd | BLIT copy sprite | WAIT_SWAP await frame_start
module sprite_frame_renderer #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int PIX_W      = 8,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int N_SPR      = 16,
  parameter int Q_DEPTH    = 32,
  parameter int SCALE_LOG2 = 2,
  parameter logic [PIX_W-1:0] TRANSP = 8'hE3,
  parameter logic [PIX_W-1:0] BG     = 8'h00
) (
  input  logic                    clk50,
  input  logic                    reset,
  sprite_frame_renderer_if.slave  io_bus
);
  localparam int XW      = $clog2(FB_W);
  localparam int YW      = $clog2(FB_H);
  localparam int IDW     = $clog2(N_SPR);
  localparam int SAW     = $clog2(N_SPR * SPR_W * SPR_H);
  localparam int FB_PIX  = FB_W * FB_H;
  localparam int SPR_PIX = SPR_W * SPR_H;
  localparam int FAW     = $clog2(2 * FB_PIX);
  localparam int CAW     = $clog2(FB_PIX);
  localparam int QAW     = $clog2(Q_DEPTH);
  localparam int CW      = $clog2(Q_DEPTH + 1);
  localparam int CLW     = $clog2(SPR_W);
  localparam int RW      = $clog2(SPR_H);
  localparam int CDW     = IDW + XW + YW;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_BLIT      = 3'd3;
  localparam logic [2:0] S_WAIT_SWAP = 3'd4;

  logic [2:0]       r_state;
  logic             r_front;
  logic             r_busy;
  logic             r_done;
  logic [CAW-1:0]   r_clr_addr;
  logic [CDW-1:0]   r_q [Q_DEPTH];
  logic [QAW-1:0]   r_wp;
  logic [QAW-1:0]   r_rp;
  logic [CW-1:0]    r_cnt;
  logic [IDW-1:0]   r_id;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [RW-1:0]    r_row;
  logic [CLW-1:0]   r_col;
  logic             r_drain;
  logic             r_wr_v;
  logic [XW:0]      r_px;
  logic [YW:0]      r_py;
  logic [PIX_W-1:0] r_fb [2*FB_PIX];
  logic [PIX_W-1:0] r_rd_data;
  logic             r_rd_act;

  logic             w_cmd_ready;
  logic             w_push;
  logic             w_issue;
  logic             w_blit_we;
  logic [SAW-1:0]   w_spr_addr;
  logic [FAW-1:0]   w_back_base;
  logic [FAW-1:0]   w_front_base;
  logic             w_fb_we;
  logic [FAW-1:0]   w_fb_waddr;
  logic [PIX_W-1:0] w_fb_wdata;
  logic [9:0]       w_rd_x;
  logic [9:0]       w_rd_y;
  logic [FAW-1:0]   w_rd_addr;

  function automatic logic [QAW-1:0] f_inc(input logic [QAW-1:0] p);
    return (p == QAW'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_cmd_ready  = (r_state == S_IDLE) && (r_cnt < CW'(Q_DEPTH));
  assign w_push       = io_bus.cmd_valid && w_cmd_ready;
  assign w_issue      = (r_state == S_BLIT) && !r_drain;
  assign w_spr_addr   = SAW'(r_id) * SAW'(SPR_PIX) + SAW'(r_row) * SAW'(SPR_W) + SAW'(r_col);
  assign w_back_base  = r_front ? '0 : FAW'(FB_PIX);
  assign w_front_base = r_front ? FAW'(FB_PIX) : '0;

  // Clip on the widened sums so off-screen pixels never alias onto a wrapped address.
  assign w_blit_we = r_wr_v && (io_bus.spr_din != TRANSP) &&
                     (r_px < (XW+1)'(FB_W)) && (r_py < (YW+1)'(FB_H));

  always_comb begin
    w_fb_we    = 1'b0;
    w_fb_waddr = '0;
    w_fb_wdata = BG;
    if (r_state == S_CLEAR) begin
      w_fb_we    = 1'b1;
      w_fb_waddr = w_back_base + FAW'(r_clr_addr);
    end else if (w_blit_we) begin
      w_fb_we    = 1'b1;
      w_fb_waddr = w_back_base + FAW'(r_py) * FAW'(FB_W) + FAW'(r_px);
      w_fb_wdata = io_bus.spr_din;
    end
  end

  assign w_rd_x    = io_bus.scan_x >> SCALE_LOG2;
  assign w_rd_y    = io_bus.scan_y >> SCALE_LOG2;
  assign w_rd_addr = w_front_base + FAW'(w_rd_y) * FAW'(FB_W) + FAW'(w_rd_x);

  always_ff @(posedge clk50) begin
    if (w_fb_we) r_fb[w_fb_waddr] <= w_fb_wdata;
    r_rd_data <= r_fb[w_rd_addr];
  end

  always_ff @(posedge clk50) begin
    if (w_push) r_q[r_wp] <= io_bus.cmd_data;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) r_rd_act <= 1'b0;
    else       r_rd_act <= io_bus.scan_active;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_front    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr_addr <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_id       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_drain    <= 1'b0;
      r_wr_v     <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
    end else begin
      r_done <= 1'b0;
      r_wr_v <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_wp  <= f_inc(r_wp);
            r_cnt <= r_cnt + 1'b1;
          end
          if (io_bus.do_render) begin
            r_state    <= S_CLEAR;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
          end
        end
        S_CLEAR: begin
          if (r_clr_addr == CAW'(FB_PIX - 1)) r_state <= S_FETCH;
          else                                r_clr_addr <= r_clr_addr + 1'b1;
        end
        S_FETCH: begin
          if (r_cnt == '0) begin
            if (io_bus.frame_start) begin
              r_front <= ~r_front;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT_SWAP;
            end
          end else begin
            {r_id, r_x, r_y} <= r_q[r_rp];
            r_rp    <= f_inc(r_rp);
            r_cnt   <= r_cnt - 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_drain <= 1'b0;
            r_state <= S_BLIT;
          end
        end
        S_BLIT: begin
          if (r_drain) begin
            r_state <= S_FETCH;
          end else begin
            r_wr_v <= 1'b1;
            r_px   <= {1'b0, r_x} + (XW+1)'(r_col);
            r_py   <= {1'b0, r_y} + (YW+1)'(r_row);
            if (r_col == CLW'(SPR_W - 1)) begin
              r_col <= '0;
              if (r_row == RW'(SPR_H - 1)) r_drain <= 1'b1;
              else                         r_row   <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_WAIT_SWAP: begin
          if (io_bus.frame_start) begin
            r_front <= ~r_front;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.cmd_ready      = w_cmd_ready;
  assign io_bus.busy           = r_busy;
  assign io_bus.done_rendering = r_done;
  assign io_bus.spr_addr       = w_spr_addr;
  assign io_bus.spr_rd         = w_issue;
  assign io_bus.pix_data       = r_rd_act ? r_rd_data : '0;
endmodule

// File: tb/tb_sprite_frame_renderer.sv
// Directed bench for sprite_frame_renderer: render, clip, painter order, queue full, reset abort.
module tb_sprite_frame_renderer;
  logic clk50 = 1'b0;
  logic reset;
  always #10 clk50 = ~clk50;

  sprite_frame_renderer_if bus ();
  sprite_frame_renderer dut (.clk50(clk50), .reset(reset), .io_bus(bus));

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;

  // Sprite ROM: 0 solid 3C, 1 solid 55, 2 checker TRANSP/1C, 3 solid 77.
  function automatic logic [7:0] spr_pix(input logic [11:0] a);
    logic [3:0] r, c;
    r = a[7:4];
    c = a[3:0];
    case (a[11:8])
      4'd0:    return 8'h3C;
      4'd1:    return 8'h55;
      4'd2:    return (r[0] ^ c[0]) ? 8'h1C : 8'hE3;
      4'd3:    return 8'h77;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk50) if (bus.spr_rd === 1'b1) bus.spr_din <= spr_pix(bus.spr_addr);
  always @(posedge clk50) if (bus.spr_rd === 1'b1) rd_cnt <= rd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan_chk(input string tag, input int sx, input int sy, input logic [7:0] exp);
    @(negedge clk50);
    bus.scan_x = 10'(sx);
    bus.scan_y = 10'(sy);
    bus.scan_active = 1'b1;
    @(negedge clk50);
    chk(tag, 32'(bus.pix_data), 32'(exp));
    bus.scan_active = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input int x, input int y);
    @(negedge clk50);
    bus.cmd_valid = 1'b1;
    bus.cmd_data = {id, 8'(x), 7'(y)};
    @(negedge clk50);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int limit, output int busy_cyc, output int dones);
    busy_cyc = 0;
    dones = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done_rendering === 1'b1) dones++;
      if (bus.busy !== 1'b1) break;
      busy_cyc++;
      @(negedge clk50);
    end
  endtask

  initial begin
    int bc, dn, cyc, rd0, bseen;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.do_render = 1'b0;
    bus.scan_x = '0;
    bus.scan_y = '0;
    bus.scan_active = 1'b0;
    bus.frame_start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);

    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done_rendering), 0);
    chk("rst_spr_rd", 32'(bus.spr_rd), 0);
    chk("rst_spr_addr", 32'(bus.spr_addr), 0);
    scan_chk("rst_pix_blank", 0, 0, 8'h00);

    // Frame 1: painter order, clipping, queue filled to depth.
    push(4'd1, 10, 20);
    push(4'd2, 10, 20);
    push(4'd2, 50, 50);
    push(4'd1, 50, 50);
    push(4'd0, 150, 110);
    for (int i = 0; i < 27; i++) push(4'd1, 120, 0);
    @(negedge clk50);
    chk("q_full_ready", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_data = {4'd3, 8'd0, 7'd60};
    bus.do_render = 1'b1;
    bus.frame_start = 1'b1;
    rd0 = rd_cnt;
    @(negedge clk50);
    bus.do_render = 1'b0;
    chk("busy_ready_low", 32'(bus.cmd_ready), 0);
    run_until_idle(30000, bc, dn);
    chk("render_cycles", bc, 19200 + 32 * 258 + 1);
    chk("done_once", dn, 1);
    chk("rd_count", rd_cnt - rd0, 32 * 256);
    chk("swap_ready", 32'(bus.cmd_ready), 1);
    @(negedge clk50);
    bus.cmd_valid = 1'b0;
    bus.frame_start = 1'b0;
    chk("done_1cyc", 32'(bus.done_rendering), 0);

    scan_chk("spr1_tl", 40, 80, 8'h55);
    scan_chk("upscale", 43, 83, 8'h55);
    scan_chk("ovl_opaque", 44, 80, 8'h1C);
    scan_chk("left_bg", 36, 80, 8'h00);
    scan_chk("spr1_br", 100, 140, 8'h55);
    scan_chk("ovl_br_opaque", 96, 140, 8'h1C);
    scan_chk("right_bg", 104, 140, 8'h00);
    scan_chk("hidden_a", 200, 200, 8'h55);
    scan_chk("hidden_b", 204, 200, 8'h55);
    scan_chk("clip_tl", 600, 440, 8'h3C);
    scan_chk("clip_br", 636, 476, 8'h3C);
    scan_chk("no_wrap_0_111", 0, 444, 8'h00);
    scan_chk("no_wrap_5_112", 20, 448, 8'h00);
    scan_chk("no_wrap_150_0", 600, 0, 8'h00);

    // Frame 2: held command (sprite 3) starts blitting, then reset aborts it.
    @(negedge clk50);
    bus.do_render = 1'b1;
    rd0 = rd_cnt;
    @(negedge clk50);
    bus.do_render = 1'b0;
    cyc = 1;
    while (bus.spr_rd !== 1'b1 && cyc < 20000) begin
      @(negedge clk50);
      cyc++;
    end
    chk("first_rd_cycle", cyc, 19202);
    repeat (37) @(negedge clk50);
    chk("spr_addr_805", 32'(bus.spr_addr), 805);
    chk("spr_rd_mid", 32'(bus.spr_rd), 1);
    repeat (40) @(negedge clk50);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done_rendering), 0);
    @(negedge clk50);
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.cmd_ready), 1);
    chk("abort_spr_rd", 32'(bus.spr_rd), 0);
    scan_chk("abort_front0_spr", 4, 240, 8'h77);
    scan_chk("abort_front0_bg", 40, 80, 8'h00);

    // Frame 3: empty queue, second do_render ignored, hold until frame_start.
    @(negedge clk50);
    bus.do_render = 1'b1;
    rd0 = rd_cnt;
    @(negedge clk50);
    bus.do_render = 1'b0;
    chk("empty_busy", 32'(bus.busy), 1);
    repeat (100) @(negedge clk50);
    bus.do_render = 1'b1;
    @(negedge clk50);
    bus.do_render = 1'b0;
    dn = 0;
    for (int i = 0; i < 19300; i++) begin
      @(negedge clk50);
      if (bus.done_rendering === 1'b1) dn++;
    end
    chk("hold_no_done", dn, 0);
    chk("hold_busy", 32'(bus.busy), 1);
    chk("empty_no_reads", rd_cnt - rd0, 0);
    bus.frame_start = 1'b1;
    @(negedge clk50);
    bus.frame_start = 1'b0;
    chk("empty_done", 32'(bus.done_rendering), 1);
    chk("empty_idle", 32'(bus.busy), 0);
    dn = 0;
    bseen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk50);
      if (bus.done_rendering === 1'b1) dn++;
      if (bus.busy === 1'b1) bseen++;
    end
    chk("no_second_done", dn, 0);
    chk("no_second_busy", bseen, 0);
    scan_chk("empty_bg_a", 40, 80, 8'h00);
    scan_chk("empty_bg_b", 200, 200, 8'h00);
    scan_chk("empty_bg_c", 600, 440, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_frame_renderer.md
Name: sprite_frame_renderer

Overview:
Parametrised successor to the single-queue VGA display engine. It accepts sprite draw commands into a bounded render queue. On a render request it clears the back framebuffer, then blits each queued sprite from external sprite memory into that buffer, with clipping and colour-key transparency. Once the frame is complete it swaps front and back buffers at the next frame start, while continuously scanning the front buffer out to the VGA pixel pipeline with integer upscaling.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
PIX_W, 8, bits per pixel (palette index / RGB332)
SPR_W, 16, sprite width in pixels
SPR_H, 16, sprite height in pixels
N_SPR, 16, number of sprites in sprite memory
Q_DEPTH, 32, render queue depth (commands)
SCALE_LOG2, 2, scan-out upscale shift (2 = 4x, 160x120 -> 640x480)
TRANSP, 8'hE3, colour key; sprite pixels equal to this are not written
BG, 8'h00, clear colour written to the back buffer before blitting

Derived widths: XW=$clog2(FB_W), YW=$clog2(FB_H), IDW=$clog2(N_SPR), SAW=$clog2(N_SPR*SPR_W*SPR_H).

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
cmd_valid  in  1  draw command offered
cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
cmd_data  in  IDW+XW+YW  {sprite_id, x, y}; x,y = top-left corner in framebuffer pixels
do_render  in  1  single-cycle pulse: render the queued commands into the back buffer
busy  out  1  high from an accepted do_render until the swap
done_rendering  out  1  one-cycle pulse on the cycle the buffers swap
spr_addr  out  SAW  sprite memory read address
spr_rd  out  1  read strobe
spr_din  in  PIX_W  sprite data; valid exactly 1 cycle after spr_rd
scan_x  in  10  current VGA column, 0..639
scan_y  in  10  current VGA row, 0..479
scan_active  in  1  VGA_BLANK_n equivalent
frame_start  in  1  one-cycle pulse at the start of vertical blank
pix_data  out  PIX_W  scan-out pixel; 1-cycle latency from scan_x/scan_y

Behaviour:
- Reset (async): state=IDLE, queue empty, front=buf0, busy=0, done_rendering=0, spr_rd=0, spr_addr=0, pix_data=0, cmd_ready=1. Buffer contents are undefined after reset.
- Queue: FIFO of Q_DEPTH entries.
  - cmd_ready = (state==IDLE) && (count<Q_DEPTH).
  - Pushes are accepted only in IDLE. A command offered while full or busy is held off by cmd_ready=0 and is not dropped.
- do_render is sampled only in IDLE; it is ignored while busy. If cmd_valid and do_render coincide in IDLE, the command is pushed first and is included in the frame.
- FSM: IDLE -> CLEAR -> FETCH -> BLIT -> FETCH ... -> WAIT_SWAP -> IDLE.
  - CLEAR: writes BG to back-buffer addresses 0..FB_W*FB_H-1, one per cycle (19200 cycles at defaults). It then goes to FETCH.
  - FETCH: one cycle. If the queue is empty, go to WAIT_SWAP. Otherwise pop the head into {id,x,y}, set row=col=0, and go to BLIT.
  - BLIT: one sprite pixel per cycle.
    - spr_addr = id*SPR_W*SPR_H + row*SPR_W + col; spr_rd=1.
    - col increments each cycle; on col==SPR_W-1 it wraps to 0 and row increments.
    - After the issue at row==SPR_H-1, col==SPR_W-1, one drain cycle covers the final write, then the FSM goes to FETCH.
    - One sprite costs SPR_W*SPR_H+1 cycles (+1 for FETCH).
  - Write pipeline: px=x+col, py=y+row, registered alongside spr_rd. On the following cycle, the back buffer at py*FB_W+px is written with spr_din, unless spr_din==TRANSP, px>=FB_W, or py>=FB_H. The px/py sums are computed at XW+1 / YW+1 bits so there is no wrap.
  - WAIT_SWAP: hold until frame_start.
    - On that cycle front toggles, done_rendering=1, busy=0, and state=IDLE.
    - A frame_start that coincides with entry into WAIT_SWAP swaps on that same cycle.
- Later commands overwrite earlier ones: queue order equals painter's order.
- Scan-out runs independently of the FSM.
  - Read address = (scan_y>>SCALE_LOG2)*FB_W + (scan_x>>SCALE_LOG2), taken from the front buffer.
  - pix_data is registered: buffer data when scan_active was high on the previous cycle, else 0.
  - A frame_start swap changes the buffer read from the next cycle; no torn frame occurs, since the swap happens in blank.
- The FSM never writes the front buffer, and scan-out never reads the back buffer.
- Reset asserted mid-CLEAR or mid-BLIT aborts immediately: queue flushed, front=buf0, no done_rendering pulse.

Test Plan:
- Reset, then scan (0,0) with scan_active=1 -> pix_data=0 one cycle later; cmd_ready=1, busy=0.
- Push {id=1,x=10,y=20} with sprite 1 all 8'h55, do_render, then frame_start -> done_rendering exactly once. Front pixel (10,20)..(25,35)=8'h55, and (9,20)=BG. Scan (40,80) -> 8'h55; scan (36,80) -> 8'h00.
- Sprite 2 with checkerboard TRANSP/8'h1C drawn over sprite 1 at the same x,y -> TRANSP positions read 8'h55, others 8'h1C. Order reversed -> sprite 2 fully hidden.
- Push {id=0,x=150,y=110} -> only the 10x10 in-bounds pixels are written, and no write lands at the wrapped address (0,111) or (150,0). Push Q_DEPTH+1 commands -> cmd_ready=0 after 32, and the 33rd is held and accepted only after the swap.
- do_render with an empty queue -> CLEAR then WAIT_SWAP, and the frame is all BG after the swap. A second do_render while busy is ignored: exactly one done_rendering. Assert reset mid-BLIT -> busy=0 next cycle, queue empty, no done pulse.
- Check cycle counts: busy-to-WAIT_SWAP for one sprite = 19200+1+257 = 19458 cycles. spr_addr for id=3,row=2,col=5 = 3*256+2*16+5 = 805.
